// File: rtl/dsp_t1_pkg.sv
// Shared widths, feedback encodings and output-select codes for the K6N10F DSP tile model.
package dsp_t1_pkg;

    localparam int unsigned NBITS_A   = 20;
    localparam int unsigned NBITS_B   = 18;
    localparam int unsigned NBITS_Z   = 38;
    localparam int unsigned NBITS_ACC = 64;

    typedef enum logic [2:0] {
        FB_ACC  = 3'd0,
        FB_ZERO = 3'd1,
        FB_FIR  = 3'd2
    } fb_e;

    localparam logic [2:0] OS_PROD     = 3'd0;
    localparam logic [2:0] OS_ACC      = 3'd1;
    localparam logic [2:0] OS_SUM      = 3'd2;
    localparam logic [2:0] OS_PROD_REG = 3'd3;
    localparam logic [2:0] OS_SUM_REG  = 3'd4;

    // Signed unless both operands are flagged unsigned.
    function automatic logic [NBITS_ACC-1:0] ext_z(input logic [NBITS_Z-1:0] v, input logic uns);
        return uns ? {{(NBITS_ACC-NBITS_Z){1'b0}}, v} : {{(NBITS_ACC-NBITS_Z){v[NBITS_Z-1]}}, v};
    endfunction

endpackage

// File: rtl/dsp_t1_postproc.sv
// Round, arithmetic/logical shift and optional saturation of a 64-bit value down to 38 bits.
module dsp_t1_postproc
    import dsp_t1_pkg::*;
#(
    parameter logic [5:0] SHIFT_RIGHT     = 6'h0,
    parameter logic       ROUND           = 1'b0,
    parameter logic       SATURATE_ENABLE = 1'b0
) (
    input  logic [NBITS_ACC-1:0] v_i,
    input  logic                 unsigned_i,
    output logic [NBITS_Z-1:0]   z_o
);

    localparam logic [NBITS_ACC-1:0] RoundInc =
        (ROUND && (SHIFT_RIGHT != 6'd0)) ? (64'd1 << (SHIFT_RIGHT - 6'd1)) : 64'd0;

    logic [NBITS_ACC-1:0] rounded;
    logic [NBITS_ACC-1:0] shifted;

    always_comb begin
        rounded = v_i + RoundInc;
        // Kept as separate assignments so the signed shift stays arithmetic.
        if (unsigned_i) begin
            shifted = rounded >> SHIFT_RIGHT;
        end else begin
            shifted = $signed(rounded) >>> SHIFT_RIGHT;
        end

        z_o = shifted[NBITS_Z-1:0];
        if (SATURATE_ENABLE) begin
            if (unsigned_i) begin
                if (|shifted[NBITS_ACC-1:NBITS_Z]) begin
                    z_o = {NBITS_Z{1'b1}};
                end
            end else if (!((&shifted[NBITS_ACC-1:NBITS_Z-1]) ||
                           !(|shifted[NBITS_ACC-1:NBITS_Z-1]))) begin
                z_o = shifted[NBITS_ACC-1] ? {1'b1, {(NBITS_Z-1){1'b0}}}
                                           : {1'b0, {(NBITS_Z-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/dsp_t1_sim_cfg_params.sv
// 20x18 multiply feeding a 64-bit accumulator; post-processing fixed by parameters.
module dsp_t1_sim_cfg_params
    import dsp_t1_pkg::*;
#(
    parameter logic       REGISTER_INPUTS = 1'b0,
    parameter logic [2:0] OUTPUT_SELECT   = 3'h0,
    parameter logic       SATURATE_ENABLE = 1'b0,
    parameter logic [5:0] SHIFT_RIGHT     = 6'h0,
    parameter logic       ROUND           = 1'b0,
    parameter logic       SUBTRACT        = 1'b0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NBITS_A-1:0]   a_i,
    input  logic [NBITS_B-1:0]   b_i,
    input  logic [5:0]           acc_fir_i,
    input  logic                 unsigned_a_i,
    input  logic                 unsigned_b_i,
    input  logic [2:0]           feedback_i,
    input  logic                 load_acc_i,
    output logic [NBITS_Z-1:0]   z_o,
    output logic [NBITS_B-1:0]   dly_b_o
);

    logic [NBITS_A-1:0]   a_q, a_s;
    logic [NBITS_B-1:0]   b_q, b_s;
    logic [5:0]           acc_fir_q, acc_fir_s;
    logic                 unsigned_a_q, unsigned_a_s;
    logic                 unsigned_b_q, unsigned_b_s;
    logic [2:0]           feedback_q, feedback_s;
    logic                 load_acc_q, load_acc_s;

    logic [NBITS_ACC-1:0] acc_q, acc_d;
    logic [NBITS_Z-1:0]   z_q, z_d;
    logic [NBITS_B-1:0]   dly_b_q;

    logic                 uns;
    logic [NBITS_Z-1:0]   a_ext38, b_ext38, prod38;
    logic [NBITS_ACC-1:0] a_ext64, prod_use, operand, sum;
    logic [NBITS_Z-1:0]   pp_acc, pp_sum;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            a_q          <= '0;
            b_q          <= '0;
            acc_fir_q    <= '0;
            unsigned_a_q <= 1'b0;
            unsigned_b_q <= 1'b0;
            feedback_q   <= '0;
            load_acc_q   <= 1'b0;
            acc_q        <= '0;
            z_q          <= '0;
            dly_b_q      <= '0;
        end else begin
            a_q          <= a_i;
            b_q          <= b_i;
            acc_fir_q    <= acc_fir_i;
            unsigned_a_q <= unsigned_a_i;
            unsigned_b_q <= unsigned_b_i;
            feedback_q   <= feedback_i;
            load_acc_q   <= load_acc_i;
            acc_q        <= acc_d;
            z_q          <= z_d;
            dly_b_q      <= b_i;
        end
    end

    always_comb begin
        a_s          = REGISTER_INPUTS ? a_q          : a_i;
        b_s          = REGISTER_INPUTS ? b_q          : b_i;
        acc_fir_s    = REGISTER_INPUTS ? acc_fir_q    : acc_fir_i;
        unsigned_a_s = REGISTER_INPUTS ? unsigned_a_q : unsigned_a_i;
        unsigned_b_s = REGISTER_INPUTS ? unsigned_b_q : unsigned_b_i;
        feedback_s   = REGISTER_INPUTS ? feedback_q   : feedback_i;
        load_acc_s   = REGISTER_INPUTS ? load_acc_q   : load_acc_i;
    end

    always_comb begin
        uns     = unsigned_a_s & unsigned_b_s;
        a_ext38 = uns ? {18'b0, a_s} : {{18{a_s[NBITS_A-1]}}, a_s};
        b_ext38 = uns ? {20'b0, b_s} : {{20{b_s[NBITS_B-1]}}, b_s};
        a_ext64 = uns ? {44'b0, a_s} : {{44{a_s[NBITS_A-1]}}, a_s};
        // Low 38 bits of a two's-complement product are sign-agnostic.
        prod38  = a_ext38 * b_ext38;

        prod_use = ext_z(prod38, uns);
        case (feedback_s)
            FB_ACC:  operand = acc_q;
            FB_FIR: begin
                operand  = a_ext64 << acc_fir_s;
                prod_use = '0;
            end
            default: operand = '0;
        endcase

        sum   = SUBTRACT ? (operand - prod_use) : (operand + prod_use);
        acc_d = load_acc_s ? sum : acc_q;
        z_d   = (OUTPUT_SELECT == OS_PROD_REG) ? prod38 : pp_sum;
    end

    dsp_t1_postproc #(
        .SHIFT_RIGHT     (SHIFT_RIGHT),
        .ROUND           (ROUND),
        .SATURATE_ENABLE (SATURATE_ENABLE)
    ) u_pp_acc (
        .v_i        (acc_q),
        .unsigned_i (uns),
        .z_o        (pp_acc)
    );

    dsp_t1_postproc #(
        .SHIFT_RIGHT     (SHIFT_RIGHT),
        .ROUND           (ROUND),
        .SATURATE_ENABLE (SATURATE_ENABLE)
    ) u_pp_sum (
        .v_i        (sum),
        .unsigned_i (uns),
        .z_o        (pp_sum)
    );

    always_comb begin
        case (OUTPUT_SELECT)
            OS_ACC:      z_o = pp_acc;
            OS_SUM:      z_o = pp_sum;
            OS_PROD_REG: z_o = z_q;
            OS_SUM_REG:  z_o = z_q;
            default:     z_o = prod38;
        endcase
    end

    assign dly_b_o = dly_b_q;

endmodule

// File: tb/tb_dsp_t1_sim_cfg_params.sv
// Drives several parameterisations of the DSP tile from shared inputs and checks them against a model.
module tb_dsp_t1_sim_cfg_params;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] a;
    logic [17:0] b;
    logic [5:0]  fir;
    logic        ua, ub;
    logic [2:0]  fb;
    logic        ld;

    logic [37:0] z0, z1, z2, z3, z4, z5, z6;
    logic [17:0] d0, d1, d2, d3, d4, d5, d6;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // u0: registered inputs, combinational product.
    dsp_t1_sim_cfg_params #(.REGISTER_INPUTS(1'b1), .OUTPUT_SELECT(3'd0)) u0 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z0), .dly_b_o(d0));
    dsp_t1_sim_cfg_params #(.OUTPUT_SELECT(3'd1)) u1 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z1), .dly_b_o(d1));
    dsp_t1_sim_cfg_params #(.OUTPUT_SELECT(3'd1), .SATURATE_ENABLE(1'b1)) u2 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z2), .dly_b_o(d2));
    dsp_t1_sim_cfg_params #(.OUTPUT_SELECT(3'd1), .SHIFT_RIGHT(6'd2), .ROUND(1'b1)) u3 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z3), .dly_b_o(d3));
    dsp_t1_sim_cfg_params #(.OUTPUT_SELECT(3'd1), .SHIFT_RIGHT(6'd2)) u4 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z4), .dly_b_o(d4));
    dsp_t1_sim_cfg_params #(.OUTPUT_SELECT(3'd1), .SUBTRACT(1'b1)) u5 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z5), .dly_b_o(d5));
    // u6: registered inputs, registered post-processed sum, full post-processing enabled.
    dsp_t1_sim_cfg_params #(.REGISTER_INPUTS(1'b1), .OUTPUT_SELECT(3'd4),
                            .SATURATE_ENABLE(1'b1), .SHIFT_RIGHT(6'd3), .ROUND(1'b1),
                            .SUBTRACT(1'b1)) u6 (
        .clock_i(clk), .reset_i(rst_n), .a_i(a), .b_i(b), .acc_fir_i(fir),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .feedback_i(fb), .load_acc_i(ld),
        .z_o(z6), .dly_b_o(d6));

    typedef struct {
        longint unsigned a, b, fir, fb;
        bit ua, ub, ld;
    } xin_t;

    localparam longint MaxS = (64'sd1 <<< 37) - 1;
    localparam longint MinS = -(64'sd1 <<< 37);

    function automatic bit m_uns(input xin_t x);
        return x.ua && x.ub;
    endfunction

    function automatic longint m_a(input xin_t x);
        if (m_uns(x)) return longint'(x.a);
        return (x.a >= 64'd524288) ? longint'(x.a) - 1048576 : longint'(x.a);
    endfunction

    function automatic longint m_b(input xin_t x);
        if (m_uns(x)) return longint'(x.b);
        return (x.b >= 64'd131072) ? longint'(x.b) - 262144 : longint'(x.b);
    endfunction

    // Product: full precision, wrapped to 38 bits, then re-extended to 64.
    function automatic longint m_prod(input xin_t x);
        longint p;
        longint two38;
        two38 = 64'sd1 <<< 38;
        p = (m_a(x) * m_b(x)) % two38;
        if (p < 0) p += two38;
        if (!m_uns(x) && p >= (two38 / 2)) p -= two38;
        return p;
    endfunction

    function automatic longint m_sum(input xin_t x, input longint acc, input bit sub);
        longint op, pr;
        pr = m_prod(x);
        if (x.fb == 0) op = acc;
        else if (x.fb == 2) begin
            op = m_a(x) <<< x.fir;
            pr = 0;
        end else op = 0;
        return sub ? op - pr : op + pr;
    endfunction

    function automatic logic [37:0] m_pp(input longint v, input bit uns, input int sr,
                                         input bit rnd, input bit sat);
        longint w;
        longint unsigned u;
        w = v;
        if (rnd && sr > 0) w = w + (64'sd1 <<< (sr - 1));
        if (uns) begin
            u = longint'(w);
            u = u >> sr;
            if (sat && u > 64'h3F_FFFF_FFFF) u = 64'h3F_FFFF_FFFF;
            return u[37:0];
        end
        w = w >>> sr;
        if (sat) begin
            if (w > MaxS) w = MaxS;
            if (w < MinS) w = MinS;
        end
        return w[37:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input xin_t x);
        a   = x.a[19:0];
        b   = x.b[17:0];
        fir = x.fir[5:0];
        fb  = x.fb[2:0];
        ua  = x.ua;
        ub  = x.ub;
        ld  = x.ld;
    endtask

    task automatic set_dir(input longint unsigned av, input longint unsigned bv,
                           input int fbv, input bit ldv);
        xin_t x;
        x = '{a: av, b: bv, fir: 0, fb: fbv, ua: 1'b0, ub: 1'b0, ld: ldv};
        drive(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        xin_t   cur, prev;
        longint acc_m, zexp, tot, pval;

        rst_n = 1'b0;
        set_dir(0, 0, 0, 0);
        #23;
        check("rst_z0", z0, 0);
        check("rst_z1", z1, 0);
        check("rst_z3", z3, 0);
        check("rst_z6", z6, 0);
        check("rst_dly", d0, 0);

        // Random phase: u0 product latency, u6 registered sum against the model.
        @(negedge clk);
        rst_n = 1'b1;
        prev  = '{a: 0, b: 0, fir: 0, fb: 0, ua: 1'b0, ub: 1'b0, ld: 1'b0};
        acc_m = 0;
        for (int i = 0; i < 100; i++) begin
            cur.a   = $urandom_range(0, 20'hFFFFF);
            cur.b   = $urandom_range(0, 18'h3FFFF);
            cur.fir = $urandom_range(0, 40);
            cur.fb  = $urandom_range(0, 7);
            cur.ua  = $urandom_range(0, 1);
            cur.ub  = (i < 30) ? cur.ua : 1'($urandom_range(0, 1));
            cur.ld  = $urandom_range(0, 3) != 0;
            drive(cur);
            tick();
            tot  = m_sum(prev, acc_m, 1'b1);
            zexp = longint'(m_pp(tot, m_uns(prev), 3, 1'b1, 1'b1));
            if (prev.ld) acc_m = tot;
            check("rnd_prod", z0, m_prod(cur) & 64'h3F_FFFF_FFFF);
            check("rnd_sumreg", z6, zexp);
            check("rnd_dly", d0, cur.b);
            prev = cur;
            @(negedge clk);
        end

        // Product sign and extremes through u0.
        set_dir(20'hFFFFD, 5, 0, 0);
        tick();
        check("prod_m3x5", z0, 38'h3F_FFFF_FFF1);
        @(negedge clk);
        set_dir(20'h80000, 18'h20000, 0, 0);
        tick();
        check("prod_min_s", z0, 64'd1 << 36);
        @(negedge clk);
        ua = 1'b1;
        ub = 1'b1;
        tick();
        check("prod_min_u", z0, 64'd1 << 36);

        // Plain accumulation 3*4.
        do_reset();
        set_dir(3, 4, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("acc_3x4", z1, 12 * k);
            check("acc_rnd", z3, m_pp(12 * k, 1'b0, 2, 1'b1, 1'b0));
            check("acc_sub", z5, m_pp(-12 * k, 1'b0, 0, 1'b0, 0));
            @(negedge clk);
        end
        fb = 3'd1;
        tick();
        check("acc_fb1", z1, 12);
        @(negedge clk);
        fb = 3'd5;
        tick();
        check("acc_fb5", z1, 12);

        // Round/shift and subtract from a cleared accumulator.
        do_reset();
        set_dir(2, 3, 0, 1);
        tick();
        check("shr_round", z3, 2);
        check("shr_trunc", z4, 1);
        check("sub_m6", z5, 38'h3F_FFFF_FFFA);

        // FIR preload: 5 << 3.
        @(negedge clk);
        set_dir(5, 7, 2, 1);
        fir = 6'd3;
        tick();
        check("fir_preload", z1, 40);

        // Saturation at the positive rail.
        do_reset();
        set_dir(20'h7FFFF, 18'h1FFFF, 0, 1);
        pval = 64'sd524287 * 64'sd131071;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tot = pval * k;
            check("sat_clamp", z2, (tot > MaxS) ? MaxS : tot);
            check("sat_wrap", z1, tot & 64'h3F_FFFF_FFFF);
            @(negedge clk);
        end

        // Asynchronous reset mid-accumulation.
        do_reset();
        set_dir(3, 4, 0, 1);
        for (int k = 0; k < 3; k++) tick();
        check("pre_rst_acc", z1, 36);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_z", z1, 0);
        check("async_rst_dly", d1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_acc", z1, 12);
        check("post_rst_dly", d1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
